cpu_control_unit: RTL and testbench

- Main decode/control block of the scalar CPU pipeline.
- Decodes the 5-bit opcode plus the extra opcode bit into datapath select and write-enable strobes.
- Owns the WAIT/NOP countdown timer and generates the pipeline stall.
- Issues start requests to the VPU and observes the VPU ready signal.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_wait_timer.sv | 24 ++
 rtl/cpu_control_unit.sv | 171 +++++++++++++++++
 tb/tb_cpu_control_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode constants, default timer width and the decode control bundle
// for the scalar CPU control unit.
package cpu_pkg;

    localparam int TIMER_W_DEF = 11;

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_NOT  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_LSL  = 5'b00101;
    localparam logic [4:0] OP_SR   = 5'b00110;
    localparam logic [4:0] OP_ROT  = 5'b00111;
    localparam logic [4:0] OP_MOV  = 5'b01000;
    localparam logic [4:0] OP_LDR  = 5'b01001;
    localparam logic [4:0] OP_LDU  = 5'b01010;
    localparam logic [4:0] OP_LDL  = 5'b01011;
    localparam logic [4:0] OP_ST   = 5'b01100;
    localparam logic [4:0] OP_J    = 5'b01101;
    localparam logic [4:0] OP_B    = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef struct packed {
        logic alu_to_reg;
        logic pcr_to_reg;
        logic mem_to_reg;
        logic reg_we_dst_0;
        logic reg_we_dst_1;
        logic reg_read_0;
        logic reg_read_1;
        logic mem_we;
        logic mem_re;
        logic add_immd;
        logic jump_immd;
        logic ldu;
        logic ldl;
        logic branch;
        logic jump;
        logic z_we;
        logic n_we;
        logic v_we;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/cpu_wait_timer.sv
// NOP/WAIT countdown: loads a cycle count, counts down to zero and holds there.
module cpu_wait_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] timer,
    output logic         timer_done
);

    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else if (load)
            timer <= load_value;
        else if (timer != '0)
            timer <= timer - W'(1);
    end

    assign timer_done = (timer == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Scalar CPU decode/control: opcode decode, WAIT/NOP stall timer and VPU issue.
// Optional VPU_HANDSHAKE_EN adds a VPU busy tracker and stalls on VPU not-ready.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int TIMER_W = TIMER_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         opcode,
    input  logic               x_bit,
    input  logic [TIMER_W-1:0] wait_time,
    input  logic               VPU_rdy,
    output logic               STALL_control,
    output logic               VPU_start,
    output logic               alu_to_reg,
    output logic               pcr_to_reg,
    output logic               mem_to_reg,
    output logic               reg_we_dst_0,
    output logic               reg_we_dst_1,
    output logic               reg_read_0,
    output logic               reg_read_1,
    output logic               mem_we,
    output logic               mem_re,
    output logic               add_immd,
    output logic               jump_immd,
    output logic               ldu,
    output logic               ldl,
    output logic               branch,
    output logic               jump,
    output logic               Z_we,
    output logic               N_we,
    output logic               V_we,
    output logic               halt
);

    ctrl_t              ctrl;
    logic [TIMER_W-1:0] timer;
    logic               timer_done;
    logic               set_timer;
    logic               vpu_op;
    logic               vpu_stall;
    logic               vpu_block;

    // 10000..11110 are VPU instructions; 11111 is the scalar HALT.
    assign vpu_op = opcode[4] && (opcode != OP_HALT);

`ifdef VPU_HANDSHAKE_EN
    logic vpu_busy;

    // A fresh issue wins over a ready seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            vpu_busy <= 1'b0;
        else if (VPU_start)
            vpu_busy <= 1'b1;
        else if (VPU_rdy)
            vpu_busy <= 1'b0;
    end

    assign vpu_stall = vpu_op && !VPU_rdy;
    assign vpu_block = vpu_busy;
`else
    logic unused_vpu_rdy;
    assign unused_vpu_rdy = VPU_rdy;
    assign vpu_stall      = 1'b0;
    assign vpu_block      = 1'b0;
`endif

    assign STALL_control = !timer_done || vpu_stall;
    assign set_timer     = (opcode == OP_NOP) && !STALL_control;
    assign VPU_start     = vpu_op && !STALL_control && !vpu_block;

    cpu_wait_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (set_timer),
        .load_value (wait_time),
        .timer      (timer),
        .timer_done (timer_done)
    );

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_AND, OP_OR, OP_XOR, OP_LSL, OP_SR, OP_ROT: begin
                ctrl.alu_to_reg   = 1'b1;
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.reg_read_0   = 1'b1;
                ctrl.reg_read_1   = 1'b1;
                ctrl.z_we         = 1'b1;
                ctrl.n_we         = 1'b1;
            end
            OP_NOT: begin
                ctrl.alu_to_reg   = 1'b1;
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.reg_read_0   = 1'b1;
                ctrl.z_we         = 1'b1;
                ctrl.n_we         = 1'b1;
            end
            OP_ADD: begin
                ctrl.alu_to_reg   = 1'b1;
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.reg_read_0   = 1'b1;
                ctrl.reg_read_1   = !x_bit;
                ctrl.add_immd     = x_bit;
                ctrl.z_we         = 1'b1;
                ctrl.n_we         = 1'b1;
                ctrl.v_we         = 1'b1;
            end
            OP_MOV: begin
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.reg_we_dst_1 = 1'b1;
                ctrl.reg_read_0   = 1'b1;
                ctrl.reg_read_1   = 1'b1;
            end
            OP_LDR: begin
                ctrl.mem_re       = 1'b1;
                ctrl.mem_to_reg   = 1'b1;
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.reg_read_0   = 1'b1;
            end
            OP_LDU: begin
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.ldu          = 1'b1;
                ctrl.reg_read_0   = 1'b1;
            end
            OP_LDL: begin
                ctrl.reg_we_dst_0 = 1'b1;
                ctrl.ldl          = 1'b1;
                ctrl.reg_read_0   = 1'b1;
            end
            OP_ST: begin
                ctrl.mem_we       = 1'b1;
                ctrl.reg_read_0   = 1'b1;
                ctrl.reg_read_1   = 1'b1;
            end
            OP_J: begin
                ctrl.jump         = 1'b1;
                ctrl.pcr_to_reg   = 1'b1;
                ctrl.reg_we_dst_1 = 1'b1;
                ctrl.jump_immd    = x_bit;
                ctrl.reg_read_0   = !x_bit;
            end
            OP_B:    ctrl.branch = 1'b1;
            OP_HALT: ctrl.halt   = 1'b1;
            default: ctrl = '0;
        endcase
    end

    assign alu_to_reg   = ctrl.alu_to_reg;
    assign pcr_to_reg   = ctrl.pcr_to_reg;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign reg_we_dst_0 = ctrl.reg_we_dst_0;
    assign reg_we_dst_1 = ctrl.reg_we_dst_1;
    assign reg_read_0   = ctrl.reg_read_0;
    assign reg_read_1   = ctrl.reg_read_1;
    assign mem_we       = ctrl.mem_we;
    assign mem_re       = ctrl.mem_re;
    assign add_immd     = ctrl.add_immd;
    assign jump_immd    = ctrl.jump_immd;
    assign ldu          = ctrl.ldu;
    assign ldl          = ctrl.ldl;
    assign branch       = ctrl.branch;
    assign jump         = ctrl.jump;
    assign Z_we         = ctrl.z_we;
    assign N_we         = ctrl.n_we;
    assign V_we         = ctrl.v_we;
    assign halt         = ctrl.halt;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit: decode table, wait timer,
// reset behaviour and (when VPU_HANDSHAKE_EN is defined) the VPU handshake.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic        x_bit;
    logic [10:0] wait_time;
    logic        VPU_rdy;
    logic STALL_control, VPU_start, alu_to_reg, pcr_to_reg, mem_to_reg;
    logic reg_we_dst_0, reg_we_dst_1, reg_read_0, reg_read_1, mem_we, mem_re;
    logic add_immd, jump_immd, ldu, ldl, branch, jump, Z_we, N_we, V_we, halt;

    int passed = 0;
    int total  = 0;

    // Output vector bit masks (MSB alu_to_reg ... LSB STALL_control)
    localparam logic [20:0] M_ALU  = 21'h1 << 20;
    localparam logic [20:0] M_PCR  = 21'h1 << 19;
    localparam logic [20:0] M_M2R  = 21'h1 << 18;
    localparam logic [20:0] M_WE0  = 21'h1 << 17;
    localparam logic [20:0] M_WE1  = 21'h1 << 16;
    localparam logic [20:0] M_RD0  = 21'h1 << 15;
    localparam logic [20:0] M_RD1  = 21'h1 << 14;
    localparam logic [20:0] M_MWE  = 21'h1 << 13;
    localparam logic [20:0] M_MRE  = 21'h1 << 12;
    localparam logic [20:0] M_ADDI = 21'h1 << 11;
    localparam logic [20:0] M_JI   = 21'h1 << 10;
    localparam logic [20:0] M_LDU  = 21'h1 << 9;
    localparam logic [20:0] M_LDL  = 21'h1 << 8;
    localparam logic [20:0] M_BR   = 21'h1 << 7;
    localparam logic [20:0] M_JMP  = 21'h1 << 6;
    localparam logic [20:0] M_Z    = 21'h1 << 5;
    localparam logic [20:0] M_N    = 21'h1 << 4;
    localparam logic [20:0] M_V    = 21'h1 << 3;
    localparam logic [20:0] M_HALT = 21'h1 << 2;
    localparam logic [20:0] M_VPU  = 21'h1 << 1;

    cpu_control_unit #(.TIMER_W(11)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .x_bit(x_bit),
        .wait_time(wait_time), .VPU_rdy(VPU_rdy),
        .STALL_control(STALL_control), .VPU_start(VPU_start),
        .alu_to_reg(alu_to_reg), .pcr_to_reg(pcr_to_reg), .mem_to_reg(mem_to_reg),
        .reg_we_dst_0(reg_we_dst_0), .reg_we_dst_1(reg_we_dst_1),
        .reg_read_0(reg_read_0), .reg_read_1(reg_read_1),
        .mem_we(mem_we), .mem_re(mem_re), .add_immd(add_immd), .jump_immd(jump_immd),
        .ldu(ldu), .ldl(ldl), .branch(branch), .jump(jump),
        .Z_we(Z_we), .N_we(N_we), .V_we(V_we), .halt(halt)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] outs();
        return {alu_to_reg, pcr_to_reg, mem_to_reg, reg_we_dst_0, reg_we_dst_1,
                reg_read_0, reg_read_1, mem_we, mem_re, add_immd, jump_immd,
                ldu, ldl, branch, jump, Z_we, N_we, V_we, halt, VPU_start, STALL_control};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = 5'b00000; x_bit = 1'b0; wait_time = '0; VPU_rdy = 1'b0;
        step(); step();
        total++;
        if (dut.timer !== 11'h000) $display("FAIL reset_timer got %h want 000", dut.timer);
        else passed++;
        total++;
        if (STALL_control !== 1'b0) $display("FAIL reset_stall got %b want 0", STALL_control);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (outs() !== (M_ALU | M_WE0 | M_RD0 | M_RD1 | M_Z | M_N))
            $display("FAIL reset_and_decode got %b want %b", outs(), M_ALU | M_WE0 | M_RD0 | M_RD1 | M_Z | M_N);
        else passed++;
    endtask

    task automatic test_decode();
        logic [4:0]  ops [20] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                  5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                  5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101,
                                  5'b01101, 5'b01110, 5'b10000, 5'b01000, 5'b11110};
        logic        xs  [20] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1,
                                  0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic [20:0] exp [20];
        exp[0]  = M_ALU | M_WE0 | M_RD0 | M_RD1 | M_Z | M_N;
        exp[1]  = exp[0];
        exp[2]  = exp[0];
        exp[3]  = M_ALU | M_WE0 | M_RD0 | M_Z | M_N;
        exp[4]  = M_ALU | M_WE0 | M_RD0 | M_RD1 | M_Z | M_N | M_V;
        exp[5]  = M_ALU | M_WE0 | M_RD0 | M_Z | M_N | M_V | M_ADDI;
        exp[6]  = exp[0];
        exp[7]  = exp[0];
        exp[8]  = exp[0];
        exp[9]  = M_WE0 | M_WE1 | M_RD0 | M_RD1;
        exp[10] = M_MRE | M_M2R | M_WE0 | M_RD0;
        exp[11] = M_WE0 | M_LDU | M_RD0;
        exp[12] = M_WE0 | M_LDL | M_RD0;
        exp[13] = M_MWE | M_RD0 | M_RD1;
        exp[14] = M_JMP | M_PCR | M_WE1 | M_RD0;
        exp[15] = M_JMP | M_PCR | M_WE1 | M_JI;
        exp[16] = M_BR;
        exp[17] = M_VPU;
        exp[18] = M_WE0 | M_WE1 | M_RD0 | M_RD1;
        exp[19] = M_VPU;
        VPU_rdy = 1'b1; wait_time = '0;
        for (int i = 0; i < 20; i++) begin
            opcode = ops[i]; x_bit = xs[i];
            #1;
            total++;
            if (outs() !== exp[i])
                $display("FAIL decode[%0d] op=%b x=%b got %b want %b", i, ops[i], xs[i], outs(), exp[i]);
            else passed++;
            step();
        end
        opcode = 5'b11111; x_bit = 1'b0;
        #1;
        total++;
        if (outs() !== M_HALT) $display("FAIL decode_halt got %b want %b", outs(), M_HALT);
        else passed++;
        step();
    endtask

    task automatic test_nop_zero();
        opcode = 5'b01111; wait_time = 11'h000;
        #1;
        total++;
        if (dut.set_timer !== 1'b1) $display("FAIL nop0_set_timer got %b want 1", dut.set_timer);
        else passed++;
        step();
        total++;
        if (STALL_control !== 1'b0 || dut.timer !== 11'h000)
            $display("FAIL nop0_no_stall got stall=%b timer=%h want 0/000", STALL_control, dut.timer);
        else passed++;
        opcode = 5'b00000;
        step();
    endtask

    task automatic test_long_wait();
        int cnt;
        opcode = 5'b01111; wait_time = 11'h7FF;
        #1;
        total++;
        if (STALL_control !== 1'b0) $display("FAIL long_pre_stall got %b want 0", STALL_control);
        else passed++;
        step();
        opcode = 5'b00011; wait_time = '0;
        #1;
        total++;
        if (dut.timer !== 11'h7FF || STALL_control !== 1'b1)
            $display("FAIL long_load got timer=%h stall=%b want 7ff/1", dut.timer, STALL_control);
        else passed++;
        cnt = 0;
        while (STALL_control === 1'b1 && cnt < 3000) begin
            cnt++;
            step();
        end
        total++;
        if (cnt != 2047) $display("FAIL long_stall_len got %0d want 2047", cnt);
        else passed++;
    endtask

    task automatic test_held_nop();
        int cnt;
        opcode = 5'b01111; wait_time = 11'h0FF;
        step();
        total++;
        if (dut.timer !== 11'h0FF) $display("FAIL held_load got %h want 0ff", dut.timer);
        else passed++;
        cnt = 0;
        while (STALL_control === 1'b1 && cnt < 1000) begin
            cnt++;
            step();
            if (cnt == 10) begin
                total++;
                if (dut.timer !== 11'h0F5) $display("FAIL held_no_reload got %h want 0f5", dut.timer);
                else passed++;
            end
        end
        opcode = 5'b00000;
        total++;
        if (cnt != 255) $display("FAIL held_stall_len got %0d want 255", cnt);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        opcode = 5'b01111; wait_time = 11'h104;
        step();
        opcode = 5'b00000; wait_time = '0;
        repeat (4) step();
        total++;
        if (dut.timer !== 11'h100) $display("FAIL mid_timer got %h want 100", dut.timer);
        else passed++;
        opcode = 5'b10010; VPU_rdy = 1'b1;
        #1;
        total++;
        if (VPU_start !== 1'b0 || STALL_control !== 1'b1)
            $display("FAIL mid_vpu_blocked got start=%b stall=%b want 0/1", VPU_start, STALL_control);
        else passed++;
        opcode = 5'b00000; rst = 1'b1;
        step();
        total++;
        if (dut.timer !== 11'h000 || STALL_control !== 1'b0)
            $display("FAIL mid_reset got timer=%h stall=%b want 000/0", dut.timer, STALL_control);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_vpu();
        opcode = 5'b10000; VPU_rdy = 1'b0;
        #1;
`ifdef VPU_HANDSHAKE_EN
        total++;
        if (STALL_control !== 1'b1 || VPU_start !== 1'b0)
            $display("FAIL vpu_wait got stall=%b start=%b want 1/0", STALL_control, VPU_start);
        else passed++;
        repeat (3) step();
        total++;
        if (STALL_control !== 1'b1) $display("FAIL vpu_wait_held got %b want 1", STALL_control);
        else passed++;
        VPU_rdy = 1'b1;
        #1;
        total++;
        if (STALL_control !== 1'b0 || VPU_start !== 1'b1)
            $display("FAIL vpu_issue got stall=%b start=%b want 0/1", STALL_control, VPU_start);
        else passed++;
        step();
        VPU_rdy = 1'b0;
        #1;
        total++;
        if (STALL_control !== 1'b1 || VPU_start !== 1'b0)
            $display("FAIL vpu_busy_stall got stall=%b start=%b want 1/0", STALL_control, VPU_start);
        else passed++;
        VPU_rdy = 1'b1;
        #1;
        total++;
        if (STALL_control !== 1'b0 || VPU_start !== 1'b0)
            $display("FAIL vpu_busy_suppress got stall=%b start=%b want 0/0", STALL_control, VPU_start);
        else passed++;
        step();
        total++;
        if (VPU_start !== 1'b1) $display("FAIL vpu_reissue got %b want 1", VPU_start);
        else passed++;
`else
        total++;
        if (STALL_control !== 1'b0 || VPU_start !== 1'b1)
            $display("FAIL vpu_rdy_ignored got stall=%b start=%b want 0/1", STALL_control, VPU_start);
        else passed++;
`endif
        opcode = 5'b00000;
        step();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_nop_zero();
        test_long_wait();
        test_held_nop();
        test_reset_mid();
        test_vpu();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
